mem_arbiter: RTL and testbench

Sequential arbiter and fill sequencer that shares the single unified main memory between the I-cache (IF stage) and the D-cache (MEM stage). It serialises block fills on cache misses and write-through stores, drives the memory request port, steers returning words into the requesting cache, and produces the stall signals that the pipeline stall/flush logic ORs with the hazard-unit stall.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_fill_seq.sv | 65 ++++++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
// Holds the arbiter state encoding, block geometry and the default
// memory latency / block size used by mem_arbiter and mem_fill_seq.
package mem_arb_pkg;

  // Byte-offset width of a cache block (16-byte blocks).
  localparam int BLK_OFF_W   = 4;
  // Default number of 16-bit words per block.
  localparam int DEF_WORDS   = 8;
  // Default read latency of main memory in cycles.
  localparam int DEF_MEM_LAT = 4;

  // Mask that clears the in-block byte offset.
  localparam logic [15:0] BLK_MASK = 16'hFFFF << BLK_OFF_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } arb_state_e;

  // Aligned base address of the block containing byte address a.
  function automatic logic [15:0] blk_base(input logic [15:0] a);
    return a & BLK_MASK;
  endfunction

endpackage

// File: rtl/mem_fill_seq.sv
// mem_fill_seq: block-fill sequencer used by mem_arbiter.
// Latches the block base on start, issues WORDS sequential word reads,
// counts returning words and flags the last one. Returns seen before the
// first request of this fill can possibly have come back (fewer than
// MEM_LAT cycles into the fill) are treated as stale and dropped.
module mem_fill_seq
  import mem_arb_pkg::*;
#(
  parameter int WORDS   = DEF_WORDS,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              start_addr,
  input  logic                     active,
  input  logic                     mem_data_valid,
  output logic                     issue,
  output logic [15:0]              req_addr,
  output logic                     ret_valid,
  output logic [$clog2(WORDS)-1:0] ret_idx,
  output logic                     done
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'((MEM_LAT < WORDS) ? MEM_LAT : WORDS);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(WORDS - 1);

  logic [15:0]      base_r;
  logic [CNT_W-1:0] iss_cnt_r;
  logic [IDX_W-1:0] ret_cnt_r;
  logic [15:0]      word_off_s;

  // Byte offset of the word about to be issued (word index * 2).
  assign word_off_s = 16'({iss_cnt_r[IDX_W-1:0], 1'b0});

  assign issue     = active & (iss_cnt_r < WORDS_C);
  assign req_addr  = issue ? (base_r + word_off_s) : 16'h0000;
  assign ret_valid = active & mem_data_valid & (iss_cnt_r >= LAT_C);
  assign ret_idx   = ret_cnt_r;
  assign done      = ret_valid & (ret_cnt_r == LAST_C);

  // Block base latch plus issue/return counters; cleared on every new fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r    <= 16'h0000;
      iss_cnt_r <= '0;
      ret_cnt_r <= '0;
    end else if (start) begin
      base_r    <= blk_base(start_addr);
      iss_cnt_r <= '0;
      ret_cnt_r <= '0;
    end else begin
      if (issue) begin
        iss_cnt_r <= iss_cnt_r + CNT_W'(1);
      end
      if (ret_valid) begin
        ret_cnt_r <= ret_cnt_r + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between I-cache and D-cache.
// Serialises write-through stores and block fills, drives the memory
// request port, tags returning words for the granted cache and raises
// the IF/MEM stall requests.
// Optional build macro ARB_RR_EN: round-robin between the D side and the
// I side when both are pending in IDLE (default: fixed D-side priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int WORDS   = DEF_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_miss,
  input  logic [15:0]              icache_addr,
  input  logic                     dcache_miss,
  input  logic [15:0]              dcache_addr,
  input  logic                     dcache_wr,
  input  logic [15:0]              dcache_wdata,
  input  logic                     mem_data_valid,
  input  logic [15:0]              mem_rdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  output logic                     fill_valid,
  output logic                     fill_sel,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     fill_done_i,
  output logic                     fill_done_d,
  output logic                     wr_ack,
  output logic                     stall_if,
  output logic                     stall_mem
);

  localparam int IDX_W = $clog2(WORDS);

  arb_state_e       state_r;
  arb_state_e       next_state_s;
  logic             stall_arm_r;
  logic             want_d_s;
  logic             pick_d_s;
  logic             fill_start_s;
  logic [15:0]      fill_addr_s;
  logic             fill_active_s;
  logic             seq_issue_s;
  logic [15:0]      seq_addr_s;
  logic             seq_ret_s;
  logic [IDX_W-1:0] seq_idx_s;
  logic             seq_done_s;
  logic             unused_rdata_s;

  // Fill data goes straight from memory to the caches; only its timing
  // passes through here.
  assign unused_rdata_s = ^mem_rdata;

  assign want_d_s      = dcache_wr | dcache_miss;
  assign fill_active_s = (state_r == FILL_I) || (state_r == FILL_D);

`ifdef ARB_RR_EN
  logic last_d_r;

  // D side wins unless the I side is also waiting and D was served last.
  assign pick_d_s = want_d_s & ~(icache_miss & last_d_r);

  // Remember which side received the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_r <= 1'b0;
    end else if ((state_r == IDLE) && (want_d_s || icache_miss)) begin
      last_d_r <= pick_d_s;
    end
  end
`else
  // Fixed priority: any D-side request beats the I side.
  assign pick_d_s = want_d_s;
`endif

  mem_fill_seq #(
    .WORDS   (WORDS),
    .MEM_LAT (MEM_LAT)
  ) u_fill_seq (
    .clk            (clk),
    .rst            (rst),
    .start          (fill_start_s),
    .start_addr     (fill_addr_s),
    .active         (fill_active_s),
    .mem_data_valid (mem_data_valid),
    .issue          (seq_issue_s),
    .req_addr       (seq_addr_s),
    .ret_valid      (seq_ret_s),
    .ret_idx        (seq_idx_s),
    .done           (seq_done_s)
  );

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Stalls stay low after reset until the miss lines have been sampled once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_arm_r <= 1'b0;
    end else begin
      stall_arm_r <= 1'b1;
    end
  end

  // Grant selection, memory port drive, fill steering and stall generation.
  always_comb begin
    next_state_s = state_r;
    fill_start_s = 1'b0;
    fill_addr_s  = 16'h0000;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    fill_valid   = 1'b0;
    fill_sel     = 1'b0;
    fill_word    = '0;
    fill_done_i  = 1'b0;
    fill_done_d  = 1'b0;
    wr_ack       = 1'b0;

    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          if (dcache_wr) begin
            next_state_s = WRITE;
          end else begin
            next_state_s = FILL_D;
            fill_start_s = 1'b1;
            fill_addr_s  = dcache_addr;
          end
        end else if (icache_miss) begin
          next_state_s = FILL_I;
          fill_start_s = 1'b1;
          fill_addr_s  = icache_addr;
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = dcache_addr;
        mem_wdata    = dcache_wdata;
        wr_ack       = 1'b1;
        next_state_s = IDLE;
      end
      FILL_I, FILL_D: begin
        mem_en     = seq_issue_s;
        mem_addr   = seq_addr_s;
        fill_valid = seq_ret_s;
        fill_sel   = seq_ret_s & (state_r == FILL_D);
        if (seq_ret_s) begin
          fill_word = seq_idx_s;
        end else begin
          fill_word = '0;
        end
        if (seq_done_s) begin
          fill_done_i  = (state_r == FILL_I);
          fill_done_d  = (state_r == FILL_D);
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    stall_if  = stall_arm_r & icache_miss & ~fill_done_i;
    stall_mem = stall_arm_r & ((dcache_miss & ~fill_done_d) | (dcache_wr & ~wr_ack));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized bench for mem_arbiter.
// The reference model is transaction level: it tracks which transaction
// is being served and since which cycle, and derives every expected output
// from the offset into that transaction. A pipelined memory model returns
// read data MEM_LAT cycles after each accepted read request.
module tb_mem_arbiter;

  localparam int LAT = 4;
  localparam int NW  = 8;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_addr = 16'h0000;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_addr = 16'h0000;
  logic        dcache_wr = 1'b0;
  logic [15:0] dcache_wdata = 16'h0000;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_en, mem_wr, fill_valid, fill_sel;
  logic [15:0] mem_addr, mem_wdata;
  logic [2:0]  fill_word;
  logic        fill_done_i, fill_done_d, wr_ack, stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dcache_wr(dcache_wr), .dcache_wdata(dcache_wdata),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_valid(fill_valid), .fill_sel(fill_sel), .fill_word(fill_word),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d), .wr_ack(wr_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Memory return pipeline, indexed by cycle number modulo 64.
  bit          slot_v [64];
  logic [15:0] slot_a [64];

  // Transaction-level model state: 0 none, 1 write, 2 I fill, 3 D fill.
  int          busy = 0;
  int          start_c = 0;
  logic [15:0] base_m = 16'h0000;
  bit          armed_m = 1'b0;
  bit          last_d_m = 1'b0;
  bit          drop_i = 1'b0, drop_d = 1'b0, drop_w = 1'b0;
  int          cyc = 0;

  // Observations for the directed checks.
  int done_i_c = 0, done_d_c = 0, first_iss_c = 0, wr_seen = 0;
  bit iss_arm = 1'b0;

  function automatic logic [63:0] pack_dut();
    return {20'h0, mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_sel,
            fill_word, fill_done_i, fill_done_d, wr_ack, stall_if, stall_mem};
  endfunction

  // One clock cycle: apply requests, drive memory, predict, compare, advance.
  task automatic run_cycle(input bit rv, input bit ri, input logic [15:0] ia,
                           input int rd, input logic [15:0] da, input logic [15:0] dw);
    bit en, wr, fv, sel, di, dd, ack, sif, smem, fin;
    logic [15:0] ad, wd;
    logic [2:0] wo;
    int k, sl;
    @(posedge clk);
    cyc++;
    #1;
    rst = rv;
    if (drop_i) begin icache_miss = 1'b0; drop_i = 1'b0; end
    if (drop_d) begin dcache_miss = 1'b0; drop_d = 1'b0; end
    if (drop_w) begin dcache_wr = 1'b0; drop_w = 1'b0; end
    if (ri && !icache_miss) begin icache_miss = 1'b1; icache_addr = ia; end
    if (rd != 0 && !dcache_miss && !dcache_wr) begin
      dcache_addr = da;
      if (rd == 1) dcache_miss = 1'b1;
      else begin dcache_wr = 1'b1; dcache_wdata = dw; end
    end
    sl = cyc % 64;
    mem_data_valid = slot_v[sl];
    mem_rdata = slot_v[sl] ? (slot_a[sl] ^ 16'h5A5A) : 16'h0000;
    slot_v[sl] = 1'b0;

    en = 0; wr = 0; fv = 0; sel = 0; di = 0; dd = 0; ack = 0; sif = 0; smem = 0; fin = 0;
    ad = 16'h0000; wd = 16'h0000; wo = 3'd0;
    k = cyc - start_c;
    if (!rv) begin
      if (busy == 1) begin
        en = 1; wr = 1; ad = dcache_addr; wd = dcache_wdata; ack = 1; fin = 1;
      end else if (busy >= 2) begin
        if (k < NW) begin en = 1; ad = base_m + 16'(2 * k); end
        if (k >= LAT && k < LAT + NW) begin
          fv = 1; sel = (busy == 3); wo = 3'(k - LAT);
        end
        if (k == LAT + NW - 1) begin
          fin = 1; di = (busy == 2); dd = (busy == 3);
        end
      end
      sif  = armed_m && icache_miss && !di;
      smem = armed_m && ((dcache_miss && !dd) || (dcache_wr && !ack));
    end
    #1;
    check_eq($sformatf("cyc%0d", cyc), pack_dut(),
             {20'h0, en, wr, ad, wd, fv, sel, wo, di, dd, ack, sif, smem});

    if (mem_en && !mem_wr) begin
      slot_v[(cyc + LAT) % 64] = 1'b1;
      slot_a[(cyc + LAT) % 64] = mem_addr;
      if (iss_arm) begin first_iss_c = cyc; iss_arm = 1'b0; end
    end
    if (mem_en && mem_wr) wr_seen++;
    if (fill_done_i) done_i_c = cyc;
    if (fill_done_d) done_d_c = cyc;

    if (rv) begin
      busy = 0; armed_m = 0; last_d_m = 0;
    end else begin
      armed_m = 1;
      if (fin) begin
        busy = 0;
        drop_i = di; drop_d = dd; drop_w = ack;
      end else if (busy == 0 && (dcache_wr || dcache_miss || icache_miss)) begin
        start_c = cyc + 1;
        if ((dcache_wr || dcache_miss) && !(RR && icache_miss && last_d_m)) begin
          busy = dcache_wr ? 1 : 3;
          base_m = dcache_addr & 16'hFFF0;
          last_d_m = 1;
        end else begin
          busy = 2;
          base_m = icache_addr & 16'hFFF0;
          last_d_m = 0;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 64; i++) begin slot_v[i] = 1'b0; slot_a[i] = 16'h0000; end

    // Reset state: everything low while rst is held.
    run_cycle(1'b1, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000);
    run_cycle(1'b1, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000);

    // I miss at 0x1234 straight out of reset.
    iss_arm = 1'b1;
    run_cycle(1'b0, 1'b1, 16'h1234, 0, 16'h0000, 16'h0000);
    idle_cycles(15);
    check_eq("done_i_latency", 64'(done_i_c - first_iss_c), 64'd11);

    // Single write-through store.
    w0 = wr_seen;
    run_cycle(1'b0, 1'b0, 16'h0000, 2, 16'h0040, 16'hBEEF);
    idle_cycles(3);
    check_eq("store_once", 64'(wr_seen - w0), 64'd1);

    // D miss and I miss raised together.
    done_i_c = 0; done_d_c = 0;
    run_cycle(1'b0, 1'b1, 16'h0100, 1, 16'h2000, 16'h0000);
    idle_cycles(29);
    check_eq("order_d_first", 64'(done_d_c < done_i_c), RR ? 64'd0 : 64'd1);

    // Store raised while an I fill is in progress.
    w0 = wr_seen;
    run_cycle(1'b0, 1'b1, 16'h0300, 0, 16'h0000, 16'h0000);
    idle_cycles(2);
    run_cycle(1'b0, 1'b0, 16'h0000, 2, 16'h0500, 16'h1234);
    idle_cycles(16);
    check_eq("store_after_fill", 64'(wr_seen - w0), 64'd1);

    // Top-of-memory block: no wrap past 0xFFFE.
    run_cycle(1'b0, 1'b1, 16'hFFF7, 0, 16'h0000, 16'h0000);
    idle_cycles(15);

    // Reset during the third issue of a fill, with the miss held.
    run_cycle(1'b0, 1'b1, 16'h4444, 0, 16'h0000, 16'h0000);
    idle_cycles(3);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_async", pack_dut(), 64'h0);
    slot_v[(cyc + LAT) % 64] = 1'b0;
    busy = 0; armed_m = 0; last_d_m = 0;
    run_cycle(1'b1, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000);
    run_cycle(1'b1, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000);
    idle_cycles(18);

    // Randomized traffic from both caches.
    for (int i = 0; i < 900; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      run_cycle(1'b0, ($urandom_range(0, 5) == 0), 16'($urandom()),
                (r < 2) ? 1 : ((r < 4) ? 2 : 0), 16'($urandom()), 16'($urandom()));
    end
    idle_cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
